// File: rtl/dbus_bridge.sv
// dbus_bridge: single-outstanding bridge from the core data port to NCH slave
// channels, selected by CPU_DADDR[SEL_LSB+3:SEL_LSB]. Unmapped channels
// complete immediately with ERR_DATA and raise the sticky ERR flag.
// Optional BUSY timeout is compiled in when DBUS_TIMEOUT_EN is defined.
module dbus_bridge #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned SEL_LSB  = 28,
    parameter int unsigned TMO      = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic [31:0]       CPU_DADDR,
    input  logic [31:0]       CPU_DATAO,
    input  logic [3:0]        CPU_BE,
    input  logic              CPU_WR,
    input  logic              CPU_RD,
    output logic [31:0]       CPU_DATAI,
    output logic              CPU_HLT,
    output logic [NCH-1:0]    S_REQ,
    output logic              S_WE,
    output logic [31:0]       S_ADDR,
    output logic [31:0]       S_WDATA,
    output logic [3:0]        S_BE,
    input  logic [NCH*32-1:0] S_RDATA,
    input  logic [NCH-1:0]    S_ACK,
    output logic              ERR,
    input  logic              ERR_CLR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [4:0] NCH_W = 5'(NCH);

    state_t      state_q, state_d;
    logic [3:0]  ch_q, ch_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        strobe;
    logic [3:0]  sel;
    logic        dec_ok;
    logic        ack_hit;
    logic [31:0] ack_data;
    logic        timeout;
    logic        err_set;

    assign strobe = CPU_RD | CPU_WR;
    assign sel    = CPU_DADDR[SEL_LSB +: 4];
    assign dec_ok = ({1'b0, sel} < NCH_W);

    // Pick the ack bit and read-data slice of the latched channel
    always_comb begin
        ack_hit  = 1'b0;
        ack_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_q == 4'(k)) begin
                ack_hit  = S_ACK[k];
                ack_data = S_RDATA[32*k +: 32];
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    localparam logic [7:0] TMO_W = 8'(TMO);

    logic [7:0] tmo_q, tmo_d;

    // The unacked BUSY cycle whose increment would reach TMO is the last one,
    // so S_REQ stays high for exactly TMO cycles and an ack there still wins.
    assign timeout = (state_q == ST_BUSY) && !ack_hit && ((tmo_q + 8'd1) == TMO_W);

    // Timeout counter: cleared while idle, counts unacked BUSY cycles
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if ((state_q == ST_BUSY) && !ack_hit) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    // Timeout counter register
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = dec_ok ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (ack_hit || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: stall, one-hot request and write enable
    always_comb begin
        S_REQ   = '0;
        S_WE    = 1'b0;
        CPU_HLT = 1'b0;
        case (state_q)
            ST_IDLE: CPU_HLT = strobe & ~RES;
            ST_BUSY: begin
                CPU_HLT = 1'b1;
                S_WE    = we_q;
                for (int unsigned k = 0; k < NCH; k++) begin
                    S_REQ[k] = (ch_q == 4'(k));
                end
            end
            default: ;
        endcase
    end

    // Datapath next values: request latch, read-data capture, error flag
    always_comb begin
        ch_d    = ch_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    ch_d    = sel;
                    we_d    = CPU_WR;
                    addr_d  = CPU_DADDR;
                    wdata_d = CPU_DATAO;
                    be_d    = CPU_BE;
                    if (!dec_ok) begin
                        err_set = 1'b1;
                        if (!CPU_WR) begin
                            rdata_d = ERR_DATA;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (ack_hit) begin
                    if (!we_q) begin
                        rdata_d = ack_data;
                    end
                end else if (timeout) begin
                    err_set = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                end
            end
            default: ;
        endcase
        if (err_set) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ch_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign S_ADDR    = addr_q;
    assign S_WDATA   = wdata_q;
    assign S_BE      = be_q;
    assign CPU_DATAI = rdata_q;
    assign ERR       = err_q;

endmodule
